// File: rtl/chaos_perm_pkg.sv
// chaos_perm_pkg
// Shared types and helpers for the chaos inverse permuter.
//   state_t   : controller state (S_LOAD buffers a frame, S_OUT emits it)
//   wrap_sub  : (a - b) mod dim for 0 <= a,b < dim without a runtime '%'
//   DEF_*     : default geometry; ROW_W/COL_W/ADDR_W are the widths it implies
package chaos_perm_pkg;

    typedef enum logic {S_LOAD, S_OUT} state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ROWS   = 256;
    localparam int DEF_COLS   = 256;
    localparam int DEF_KEY_W  = 8;

    localparam int ROW_W  = $clog2(DEF_ROWS);
    localparam int COL_W  = $clog2(DEF_COLS);
    localparam int ADDR_W = $clog2(DEF_ROWS * DEF_COLS);

    // Operands are already reduced below dim, so one conditional add suffices.
    function automatic logic [31:0] wrap_sub(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] dim);
        if (a >= b)
            return a - b;
        else
            return a + dim - b;
    endfunction

endpackage

// File: rtl/chaos_frame_ram.sv
// chaos_frame_ram
// Simple dual-port frame store: synchronous write, registered 1-cycle read.
// Contents are not reset.
//   clk   : clock
//   we    : write enable      waddr/wdata : write address / pixel
//   re    : read enable       raddr       : read address
//   rdata : pixel read at raddr, valid the cycle after re
module chaos_frame_ram
    import chaos_perm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_ROWS * DEF_COLS,
    parameter int AW     = ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/chaos_inverse_permuter.sv
// chaos_inverse_permuter
// Buffers one permuted frame in raster order, then streams it back out with
// the column shift and then the row shift undone, computed on the read
// address so no second frame copy is needed.
//   state | meaning
//   S_LOAD | accepting pixels and key writes
//   S_OUT  | emitting de-permuted frame; key writes stalled
// Ports:
//   clk, rst                    : clock, async active-high reset
//   key_valid/key_ready         : key write handshake
//   key_sel, key_idx, key_data  : 0 -> M[idx] (row key), 1 -> N[idx] (column key)
//   in_valid/in_ready, in_data  : input pixel stream; in_last checked only
//   out_valid/out_ready         : output stream, out_data, out_last on final pixel
//   busy                        : high while emitting
//   done                        : pulse on the final output handshake
//   len_err                     : pulse when in_last disagrees with the pixel count
module chaos_inverse_permuter
    import chaos_perm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int KEY_W  = DEF_KEY_W
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          key_valid,
    output logic                                          key_ready,
    input  logic                                          key_sel,
    input  logic [$clog2((ROWS > COLS) ? ROWS : COLS)-1:0] key_idx,
    input  logic [KEY_W-1:0]                              key_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [DATA_W-1:0]                             in_data,
    input  logic                                          in_last,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DATA_W-1:0]                             out_data,
    output logic                                          out_last,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          len_err
);

    localparam int ROW_BITS  = $clog2(ROWS);
    localparam int COL_BITS  = $clog2(COLS);
    localparam int DEPTH     = ROWS * COLS;
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int IDX_BITS  = $clog2((ROWS > COLS) ? ROWS : COLS);

    state_t                state;
    logic [ADDR_BITS-1:0]  wr_cnt;
    logic [COL_BITS-1:0]   m_key [ROWS];
    logic [ROW_BITS-1:0]   n_key [COLS];

    logic [ROW_BITS-1:0]   rd_r;
    logic [COL_BITS-1:0]   rd_c;
    logic                  issued_all;
    logic                  rd_vld;
    logic                  rd_last;
    logic [DATA_W-1:0]     rd_data;

    logic [1:0][DATA_W-1:0] sk_data;
    logic [1:0]             sk_last;
    logic                   sk_wp;
    logic                   sk_rp;
    logic [1:0]             sk_cnt;

    logic                  in_hs, key_hs, out_hs, issue, rd_at_end;
    logic [2:0]            occ;
    logic [COL_BITS-1:0]   col_src;
    logic [ROW_BITS-1:0]   row_src;
    logic [ADDR_BITS-1:0]  rd_addr;

    assign in_ready  = (state == S_LOAD);
    assign key_ready = (state == S_LOAD);
    assign busy      = (state == S_OUT);
    assign in_hs     = in_valid & in_ready;
    assign key_hs    = key_valid & key_ready;

    assign out_valid = (sk_cnt != 2'd0);
    assign out_data  = sk_data[sk_rp];
    assign out_last  = out_valid & sk_last[sk_rp];
    assign out_hs    = out_valid & out_ready;
    assign done      = out_hs & out_last;

    // A read issued now lands in the skid buffer two edges later, so only
    // issue when the buffer plus the read in flight leaves room for it.
    assign occ       = 3'(sk_cnt) + 3'(rd_vld) - 3'(out_hs);
    assign issue     = (state == S_OUT) && !issued_all && (occ <= 3'd1);
    assign rd_at_end = (rd_r == ROW_BITS'(ROWS - 1)) && (rd_c == COL_BITS'(COLS - 1));

    always_comb begin
        col_src = COL_BITS'(wrap_sub(32'(rd_c), 32'(m_key[rd_r]), 32'(COLS)));
        row_src = ROW_BITS'(wrap_sub(32'(rd_r), 32'(n_key[col_src]), 32'(ROWS)));
        rd_addr = ADDR_BITS'(32'(row_src) * 32'(COLS) + 32'(col_src));
    end

    // Keys are reduced once here so the address path only needs wrap_sub.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) m_key[i] <= '0;
            for (int i = 0; i < COLS; i++) n_key[i] <= '0;
        end else if (key_hs) begin
            if (!key_sel) begin
                for (int i = 0; i < ROWS; i++)
                    if (key_idx == IDX_BITS'(i))
                        m_key[i] <= COL_BITS'(32'(key_data) % 32'(COLS));
            end else begin
                for (int i = 0; i < COLS; i++)
                    if (key_idx == IDX_BITS'(i))
                        n_key[i] <= ROW_BITS'(32'(key_data) % 32'(ROWS));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LOAD;
            wr_cnt     <= '0;
            len_err    <= 1'b0;
            rd_r       <= '0;
            rd_c       <= '0;
            issued_all <= 1'b0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
            sk_data    <= '0;
            sk_last    <= '0;
            sk_wp      <= 1'b0;
            sk_rp      <= 1'b0;
            sk_cnt     <= 2'd0;
        end else begin
            len_err <= 1'b0;
            rd_vld  <= issue;
            rd_last <= issue && rd_at_end;

            case (state)
                S_LOAD: begin
                    if (in_hs) begin
                        if (wr_cnt == ADDR_BITS'(DEPTH - 1)) begin
                            wr_cnt  <= '0;
                            state   <= S_OUT;
                            len_err <= !in_last;
                        end else begin
                            wr_cnt  <= wr_cnt + 1'b1;
                            len_err <= in_last;
                        end
                    end
                end
                S_OUT: begin
                    if (issue) begin
                        if (rd_c == COL_BITS'(COLS - 1)) begin
                            rd_c <= '0;
                            if (rd_r == ROW_BITS'(ROWS - 1))
                                issued_all <= 1'b1;
                            else
                                rd_r <= rd_r + 1'b1;
                        end else begin
                            rd_c <= rd_c + 1'b1;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase

            if (rd_vld) begin
                sk_data[sk_wp] <= rd_data;
                sk_last[sk_wp] <= rd_last;
                sk_wp          <= ~sk_wp;
            end
            if (out_hs)
                sk_rp <= ~sk_rp;
            sk_cnt <= sk_cnt + 2'(rd_vld) - 2'(out_hs);

            // Nothing is in flight once the last pixel leaves.
            if (done) begin
                state      <= S_LOAD;
                rd_r       <= '0;
                rd_c       <= '0;
                issued_all <= 1'b0;
                sk_wp      <= 1'b0;
                sk_rp      <= 1'b0;
                sk_cnt     <= 2'd0;
            end
        end
    end

    chaos_frame_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (in_hs),
        .waddr (wr_cnt),
        .wdata (in_data),
        .re    (issue),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_chaos_inverse_permuter.sv
module tb_chaos_inverse_permuter;

    localparam int DW   = 8;
    localparam int R    = 4;
    localparam int C    = 4;
    localparam int KW   = 8;
    localparam int NPIX = R * C;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid, key_ready, key_sel;
    logic [1:0]    key_idx;
    logic [KW-1:0] key_data;
    logic          in_valid, in_ready, in_last;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_data;
    logic          busy, done, len_err;

    chaos_inverse_permuter #(
        .DATA_W (DW),
        .ROWS   (R),
        .COLS   (C),
        .KEY_W  (KW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_sel   (key_sel),
        .key_idx   (key_idx),
        .key_data  (key_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    int  pix  [NPIX];
    int  mk   [R];
    int  nk   [C];
    int  expf [NPIX];
    int  got  [NPIX];
    int  out_cnt     = 0;
    int  frame_start = 0;
    int  lerr_cnt    = 0;
    bit  rand_rdy    = 1'b0;
    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: inverse of the chaos shift, straight from the mapping rules.
    function automatic void build_model();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                int cp, sr;
                cp = ((c - mk[r]) % C + C) % C;
                sr = ((r - nk[cp]) % R + R) % R;
                expf[r * C + c] = pix[sr * C + cp];
            end
    endfunction

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin : mon
        int idx;
        if (rst) begin
            pv = 1'b0;
        end else begin
            idx = out_cnt - frame_start;
            if (pv && !pr) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), int'(pd));
                chk("hold_last", int'(out_last), int'(pl));
            end
            if (out_valid && out_ready) begin
                if (idx >= NPIX) begin
                    chk("extra_output", idx, NPIX - 1);
                end else begin
                    chk("data", int'(out_data), expf[idx]);
                    chk("last", int'(out_last), int'(idx == NPIX - 1));
                    got[idx] = int'(out_data);
                end
                chk("done", int'(done), int'(idx == NPIX - 1));
                out_cnt++;
            end else if (done) begin
                chk("done_idle", int'(done), 0);
            end
            if (len_err) lerr_cnt++;
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        end
    end

    task automatic write_key(input bit sel, input int idx, input int data);
        bit ok;
        ok = 1'b0;
        key_sel   = sel;
        key_idx   = idx[1:0];
        key_data  = data[KW-1:0];
        key_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (key_ready) ok = 1'b1;
        end
        if (!ok) chk("key_timeout", 0, 1);
        @(posedge clk);
        #1 key_valid = 1'b0;
        if (sel) nk[idx] = (data & 255) % R;
        else     mk[idx] = (data & 255) % C;
    endtask

    task automatic send_frame(input int bad_last, input bit gaps);
        for (int i = 0; i < NPIX; i++) begin
            bit ok;
            if (gaps)
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            in_valid = 1'b1;
            in_data  = pix[i][DW-1:0];
            in_last  = (i == NPIX - 1) || (i == bad_last);
            ok = 1'b0;
            for (int n = 0; n < 200 && !ok; n++) begin
                @(negedge clk);
                if (in_ready) ok = 1'b1;
            end
            if (!ok) chk("in_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_frame();
        for (int n = 0; n < 3000 && (out_cnt - frame_start) < NPIX; n++)
            @(posedge clk);
        chk("frame_complete", out_cnt - frame_start, NPIX);
        @(posedge clk);
        #1;
    endtask

    task automatic raster_pix();
        for (int i = 0; i < NPIX; i++) pix[i] = i;
    endtask

    initial begin
        int first, dk, l0;
        rst = 1'b1; key_valid = 1'b0; key_sel = 1'b0; key_idx = '0; key_data = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < R; i++) mk[i] = 0;
        for (int i = 0; i < C; i++) nk[i] = 0;

        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_len_err", int'(len_err), 0);
        chk("rst_out_data", int'(out_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_key_ready", int'(key_ready), 1);

        // 1: identity, latency and throughput
        raster_pix(); build_model();
        frame_start = out_cnt; l0 = lerr_cnt;
        send_frame(-1, 1'b0);
        chk("t1_busy", int'(busy), 1);
        first = -1; dk = -1;
        for (int k = 1; k <= 40 && dk < 0; k++) begin
            @(posedge clk);
            #1;
            if (out_valid && first < 0) first = k;
            if (done) dk = k;
        end
        chk("t1_first_valid_cycle", first, 2);
        chk("t1_done_cycle", dk, NPIX + 1);
        wait_frame();
        for (int i = 0; i < NPIX; i++) chk("t1_identity", got[i], i);
        chk("t1_len_err", lerr_cnt - l0, 0);
        chk("t1_back_to_load", int'(in_ready), 1);

        // 2: column key N[0]=1
        write_key(1'b1, 0, 1);
        raster_pix(); build_model();
        frame_start = out_cnt;
        send_frame(-1, 1'b0);
        wait_frame();
        chk("t2_o00", got[0], 12);
        chk("t2_o10", got[4], 0);
        chk("t2_o30", got[12], 8);
        for (int r = 0; r < R; r++)
            for (int c = 1; c < C; c++) chk("t2_cols_unchanged", got[r * C + c], r * C + c);

        // 3: row key with reduction, M[1]=5 -> 1
        write_key(1'b1, 0, 0);
        write_key(1'b0, 1, 5);
        raster_pix(); build_model();
        frame_start = out_cnt;
        send_frame(-1, 1'b0);
        wait_frame();
        chk("t3_o10", got[4], 7);
        chk("t3_o11", got[5], 4);
        for (int c = 0; c < C; c++) begin
            chk("t3_row0", got[c], c);
            chk("t3_row2", got[2 * C + c], 2 * C + c);
            chk("t3_row3", got[3 * C + c], 3 * C + c);
        end

        // 4: random keys, random data, random backpressure and input gaps
        rand_rdy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < R; i++) write_key(1'b0, i, int'($urandom_range(0, 255)));
            for (int i = 0; i < C; i++) write_key(1'b1, i, int'($urandom_range(0, 255)));
            for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255));
            build_model();
            frame_start = out_cnt;
            send_frame(-1, 1'b1);
            wait_frame();
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // 5: key write stalled during output; early in_last
        raster_pix(); build_model();
        frame_start = out_cnt; l0 = lerr_cnt;
        send_frame(9, 1'b0);
        chk("t5_key_ready_busy", int'(key_ready), 0);
        chk("t5_in_ready_busy", int'(in_ready), 0);
        write_key(1'b0, 0, 1);
        chk("t5_key_after_done", out_cnt - frame_start, NPIX);
        chk("t5_len_err_pulses", lerr_cnt - l0, 1);

        // 6: reset mid-output, then identity frame
        raster_pix(); build_model();
        frame_start = out_cnt;
        send_frame(-1, 1'b0);
        for (int n = 0; n < 200 && (out_cnt - frame_start) < 6; n++) @(negedge clk);
        chk("t6_reached_px6", out_cnt - frame_start, 6);
        #1 rst = 1'b1;
        #1;
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_out_last", int'(out_last), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_out_data", int'(out_data), 0);
        for (int i = 0; i < R; i++) mk[i] = 0;
        for (int i = 0; i < C; i++) nk[i] = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_in_ready", int'(in_ready), 1);
        chk("t6_key_ready", int'(key_ready), 1);
        raster_pix(); build_model();
        frame_start = out_cnt;
        send_frame(-1, 1'b0);
        wait_frame();
        for (int i = 0; i < NPIX; i++) chk("t6_identity", got[i], i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chaos_inverse_permuter.md
Name: chaos_inverse_permuter

Overview:
- Streaming, parametrised inverse of the chaos row/column shift permutation used in the image decryption path.
- Buffers one full ciphertext-permuted frame in raster order, then emits the de-permuted frame in raster order.
- Undoes the column shift first, then the row shift, as a single read-address pass; no intermediate frame copy is needed.
- Shift keys M (per row) and N (per column) are loaded through a register-write port.
- Sits between the diffusion-inverse stage and the pixel output sink.

Parameters:
- DATA_W, 8: pixel width.
- ROWS, 256: image rows (m); any value ≥2.
- COLS, 256: image columns (n); any value ≥2.
- KEY_W, 8: raw key word width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  key write strobe.
- key_ready  out  1  key write accepted when high.
- key_sel  in  1  0 = write M[key_idx] (row key); 1 = write N[key_idx] (column key).
- key_idx  in  clog2(max(ROWS,COLS))  key index.
- key_data  in  KEY_W  raw shift value.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted.
- in_data  in  DATA_W  input pixel.
- in_last  in  1  marks the final pixel of the frame (checked only).
- out_valid  out  1  output pixel valid.
- out_ready  in  1  sink ready.
- out_data  out  DATA_W  de-permuted pixel.
- out_last  out  1  high with pixel (ROWS-1, COLS-1).
- busy  out  1  high in S_OUT.
- done  out  1  one-cycle pulse on the final output handshake.
- len_err  out  1  one-cycle pulse on an in_last mismatch.

Behaviour:
- Mapping (I = buffered frame, O = output):
  - c' = (c − M[r]) mod COLS
  - O[r][c] = I[(r − N[c']) mod ROWS][c']
- Key reduction: keys are stored pre-reduced at write time: M entries as key_data mod COLS, N entries as key_data mod ROWS.
- Wrapped subtraction: compute as a − b, plus dimension if negative. Never use a signed % at runtime.
- Key index out of range: a write with key_idx ≥ the relevant dimension is accepted and ignored.
- FSM states: S_LOAD, S_OUT.
- S_LOAD:
  - in_ready = 1 and key_ready = 1.
  - Each in_valid handshake writes the pixel to buffer address wr_cnt (raster order), then wr_cnt increments.
  - At wr_cnt = ROWS*COLS−1 the handshake moves the FSM to S_OUT and clears wr_cnt.
  - len_err pulses if in_last is 1 on any earlier pixel, or 0 on the final pixel. The frame still ends by count.
- S_OUT:
  - in_ready = 0 and key_ready = 0; key writes are stalled, not dropped.
  - A raster counter (r, c) generates read addresses.
  - The buffer has 1-cycle read latency; a 2-entry output skid buffer sustains 1 pixel/cycle.
  - First out_valid appears 2 cycles after entry to S_OUT.
  - With out_ready held high, a frame takes ROWS*COLS + 2 cycles.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
  - The final output handshake pulses done, returns the FSM to S_LOAD and clears all counters.
- Simultaneous events:
  - In S_LOAD, a key write and a pixel write in the same cycle are both accepted.
  - Keys are sampled during S_OUT only; since writes are blocked there, keys are stable for the whole frame.
- Reset (asynchronous, any state including mid-frame):
  - FSM → S_LOAD; all counters and the skid buffer are cleared.
  - out_valid=0, out_last=0, done=0, len_err=0, busy=0, out_data=0.
  - All M and N entries are cleared to 0, giving the identity permutation.
  - Buffer contents are don't-care.
  - After release: in_ready=1, key_ready=1.

Decomposition:
- Package chaos_perm_pkg holds:
  - state enum {S_LOAD, S_OUT};
  - function wrap_sub(a, b, dim);
  - width localparams derived via $clog2 (ADDR_W, ROW_W, COL_W).
- Sub-module chaos_frame_ram:
  - simple dual-port, ROWS*COLS × DATA_W;
  - synchronous write, 1-cycle registered read;
  - no reset on contents.

Test Plan (ROWS=COLS=4 unless noted; input pixel value = 4r+c):
1. Identity: all keys 0, frame streamed, out_ready=1 → out_data = 0,1,…,15; out_last and done on pixel 15; first out_valid 2 cycles after last input.
2. Column key: N[0]=1, others 0 → O[0][0]=12, O[1][0]=0, O[3][0]=8; columns 1–3 unchanged.
3. Row key plus reduction: M[1] written as 5 (reduces to 1), N all 0 → O[1][0]=7, O[1][1]=4; other rows unchanged.
4. Combined keys: random M/N and random out_ready backpressure → output matches the reference model bit-for-bit; out_data is held while stalled; throughput is 1/cycle when out_ready=1.
5. Protocol: key write attempted during S_OUT → key_ready=0 until done. in_last on pixel 9 → len_err pulse, and 16 outputs still emitted.
6. Reset at output pixel 6 → outputs idle immediately; keys read back as identity; a following full frame with zero keys emits 0…15 correctly.
